// File: rtl/spi_target_bridge_if.sv
// Bus bundle for spi_target_bridge: SPI pins plus the fabric-side RX/TX handshakes and status.
interface spi_target_bridge_if;
  logic       spi_cs_b;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_get;
  logic [7:0] tx_data;
  logic       tx_put;
  logic       tx_free;
  logic       cs_active;
  logic       xfer_done;
  logic       rx_overflow;
  logic       tx_underflow;
  logic       flag_clear;

  modport slave (
    input  spi_cs_b, spi_sck, spi_mosi, rx_get, tx_data, tx_put, flag_clear,
    output spi_miso, spi_miso_oe, rx_data, rx_avail, tx_free, cs_active,
           xfer_done, rx_overflow, tx_underflow
  );

  modport master (
    output spi_cs_b, spi_sck, spi_mosi, rx_get, tx_data, tx_put, flag_clear,
    input  spi_miso, spi_miso_oe, rx_data, rx_avail, tx_free, cs_active,
           xfer_done, rx_overflow, tx_underflow
  );
endinterface

// File: rtl/spi_target_bridge.sv
// SPI mode-0 target bridging an external controller to 48 MHz fabric byte streams.
// Define SPI_TGT_STATUS_BYTE_EN to return a status byte as the first byte of every transfer.
module spi_target_bridge #(
  parameter int unsigned RX_DEPTH  = 8,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  spi_target_bridge_if.slave bus
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e        state_q, state_d;

  logic [2:0]    cs_sync_q, sck_sync_q;
  logic [1:0]    mosi_sync_q;
  logic          cs_fall, cs_rise, sck_rise, sck_fall, mosi_s;

  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rx_sr_q, rx_sr_d;
  logic [7:0]    tx_sr_q, tx_sr_d;
  logic          miso_q, miso_d;
  logic          oe_q, oe_d;
  logic          cs_active_q, cs_active_d;
  logic          xfer_done_q, xfer_done_d;
  logic [7:0]    hold_q, hold_d;
  logic          tx_free_q, tx_free_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [RX_DEPTH];
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_avail_q, rx_avail_d;

  logic          load_normal, take, unf_evt, put_ok;
  logic          push_req, push_ok, pop, full, ovf_evt;
  logic [7:0]    push_byte, next_tx;

`ifdef SPI_TGT_STATUS_BYTE_EN
  logic          load_status;
  logic [PW-1:0] rx_level;
  logic [6:0]    lvl_ext;
  logic [4:0]    lvl_sat;
  logic [7:0]    status_byte;

  assign rx_level    = wr_ptr_q - rd_ptr_q;
  assign lvl_ext     = 7'(rx_level);
  assign lvl_sat     = (lvl_ext > 7'd31) ? 5'd31 : lvl_ext[4:0];
  assign status_byte = {ovf_q, unf_q, tx_free_q, lvl_sat};
`endif

  // Stage [1] is the synchronised level; [2] is the previous value for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= 3'b111;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], bus.spi_cs_b};
      sck_sync_q  <= {sck_sync_q[1:0], bus.spi_sck};
      mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
    end
  end

  assign cs_fall  =  cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise  = ~cs_sync_q[2] &  cs_sync_q[1];
  assign sck_rise = ~sck_sync_q[2] &  sck_sync_q[1];
  assign sck_fall =  sck_sync_q[2] & ~sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign next_tx  = tx_free_q ? FILL_BYTE : hold_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    cs_active_d = cs_active_q;
    xfer_done_d = 1'b0;
    load_normal = 1'b0;
    push_req    = 1'b0;
    push_byte   = {rx_sr_q, mosi_s};
`ifdef SPI_TGT_STATUS_BYTE_EN
    load_status = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_LOAD;
          cs_active_d = 1'b1;
        end
      end
      ST_LOAD, ST_SHIFT: begin
        // CS release wins over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = 3'd0;
          rx_sr_d     = 7'd0;
          tx_sr_d     = 8'd0;
          miso_d      = 1'b0;
          oe_d        = 1'b0;
          cs_active_d = 1'b0;
          xfer_done_d = 1'b1;
        end else if (state_q == ST_LOAD) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 3'd0;
          oe_d      = 1'b1;
`ifdef SPI_TGT_STATUS_BYTE_EN
          load_status = 1'b1;
`else
          load_normal = 1'b1;
`endif
        end else if (sck_rise) begin
          rx_sr_d   = {rx_sr_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          push_req  = (bit_cnt_q == 3'd7);
        end else if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            load_normal = 1'b1;
          end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            miso_d  = tx_sr_q[6];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    take    = load_normal & ~tx_free_q;
    unf_evt = load_normal &  tx_free_q;
    if (load_normal) begin
      tx_sr_d = next_tx;
      miso_d  = next_tx[7];
    end
`ifdef SPI_TGT_STATUS_BYTE_EN
    if (load_status) begin
      tx_sr_d = status_byte;
      miso_d  = status_byte[7];
    end
`endif
  end

  // Holding register, sticky flags and RX FIFO bookkeeping.
  always_comb begin
    hold_d    = hold_q;
    tx_free_d = tx_free_q;
    put_ok    = bus.tx_put & (tx_free_q | take);
    if (put_ok) begin
      hold_d    = bus.tx_data;
      tx_free_d = 1'b0;
    end else if (take) begin
      tx_free_d = 1'b1;
    end

    pop     = bus.rx_get & rx_avail_q;
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_ok = push_req & (~full | pop);
    ovf_evt = push_req & full & ~pop;

    ovf_d = (bus.flag_clear ? 1'b0 : ovf_q) | ovf_evt;
    unf_d = (bus.flag_clear ? 1'b0 : unf_q) | unf_evt;

    wr_ptr_d   = wr_ptr_q + PW'(push_ok);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    rx_avail_d = (wr_ptr_d != rd_ptr_d);
    if (!rx_avail_d) begin
      rx_data_d = 8'd0;
    end else if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      rx_data_d = push_byte;
    end else begin
      rx_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 7'd0;
      tx_sr_q     <= 8'd0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      cs_active_q <= 1'b0;
      xfer_done_q <= 1'b0;
      hold_q      <= 8'd0;
      tx_free_q   <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rx_data_q   <= 8'd0;
      rx_avail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      cs_active_q <= cs_active_d;
      xfer_done_q <= xfer_done_d;
      hold_q      <= hold_d;
      tx_free_q   <= tx_free_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rx_data_q   <= rx_data_d;
      rx_avail_q  <= rx_avail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_byte;
    end
  end

  assign bus.spi_miso     = miso_q;
  assign bus.spi_miso_oe  = oe_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_avail     = rx_avail_q;
  assign bus.tx_free      = tx_free_q;
  assign bus.cs_active    = cs_active_q;
  assign bus.xfer_done    = xfer_done_q;
  assign bus.rx_overflow  = ovf_q;
  assign bus.tx_underflow = unf_q;

endmodule

// File: tb/tb_spi_target_bridge.sv
// Directed bench for spi_target_bridge: a mode-0 SPI controller model plus fabric RX/TX handshakes.
module tb_spi_target_bridge;
  logic       clk = 1'b0;
  logic       reset;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         xfer_cnt = 0;
  int         x0;
  logic [7:0] mi;

  spi_target_bridge_if bus ();

  spi_target_bridge #(.RX_DEPTH(4), .FILL_BYTE(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (bus.xfer_done === 1'b1) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic put_tx(input logic [7:0] b);
    bus.tx_data = b;
    bus.tx_put  = 1'b1;
    tick(1);
    bus.tx_put  = 1'b0;
    tick(1);
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] exp);
    check({tag, "_avail"}, 8'(bus.rx_avail), 8'h01);
    check(tag, bus.rx_data, exp);
    bus.rx_get = 1'b1;
    tick(1);
    bus.rx_get = 1'b0;
    tick(1);
  endtask

  task automatic cs_on;
    bus.spi_cs_b = 1'b0;
    tick(8);
  endtask

  task automatic cs_off;
    tick(4);
    bus.spi_cs_b = 1'b1;
    tick(8);
  endtask

  task automatic clear_flags;
    bus.flag_clear = 1'b1;
    tick(1);
    bus.flag_clear = 1'b0;
    tick(1);
  endtask

  // hook 1: tx_put lands on the byte-boundary transfer; hook 2: rx_get lands on the byte push.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input int hook,
                          input logic [7:0] hb, output logic [7:0] mo_rx);
    mo_rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.spi_mosi = mo[i];
      tick(4);
      bus.spi_sck = 1'b1;
      mo_rx[i] = bus.spi_miso;
      if (i == 0 && hook == 2) begin
        tick(2);
        bus.rx_get = 1'b1;
        tick(1);
        bus.rx_get = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      bus.spi_sck = 1'b0;
      if (i == 0 && hook == 1) begin
        tick(2);
        bus.tx_data = hb;
        bus.tx_put  = 1'b1;
        tick(1);
        bus.tx_put  = 1'b0;
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.spi_cs_b   = 1'b1;
    bus.spi_sck    = 1'b0;
    bus.spi_mosi   = 1'b0;
    bus.rx_get     = 1'b0;
    bus.tx_data    = 8'h00;
    bus.tx_put     = 1'b0;
    bus.flag_clear = 1'b0;
    tick(3);
    check("rst_miso", 8'(bus.spi_miso), 8'h00);
    check("rst_oe", 8'(bus.spi_miso_oe), 8'h00);
    check("rst_avail", 8'(bus.rx_avail), 8'h00);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_tx_free", 8'(bus.tx_free), 8'h01);
    check("rst_cs_active", 8'(bus.cs_active), 8'h00);
    check("rst_xfer_done", 8'(bus.xfer_done), 8'h00);
    check("rst_ovf", 8'(bus.rx_overflow), 8'h00);
    check("rst_unf", 8'(bus.tx_underflow), 8'h00);
    reset = 1'b0;
    tick(2);

    // Two-byte exchange with one preloaded TX byte, then fill.
    put_tx(8'h5A);
    check("t1_tx_free_loaded", 8'(bus.tx_free), 8'h00);
    cs_on();
    check("t1_cs_active", 8'(bus.cs_active), 8'h01);
    check("t1_oe", 8'(bus.spi_miso_oe), 8'h01);
    check("t1_tx_free_taken", 8'(bus.tx_free), 8'h01);
    spi_xfer(8'hA5, 8, 0, 8'h00, mi);
    check("t1_miso0", mi, 8'h5A);
    spi_xfer(8'h3C, 8, 0, 8'h00, mi);
    check("t1_miso1", mi, 8'hFF);
    x0 = xfer_cnt;
    cs_off();
    check("t1_xfer_pulses", 8'(xfer_cnt - x0), 8'h01);
    check("t1_cs_idle", 8'(bus.cs_active), 8'h00);
    check("t1_oe_off", 8'(bus.spi_miso_oe), 8'h00);
    check("t1_miso_off", 8'(bus.spi_miso), 8'h00);
    check("t1_unf", 8'(bus.tx_underflow), 8'h01);
    check("t1_ovf", 8'(bus.rx_overflow), 8'h00);
    pop_rx("t1_pop0", 8'hA5);
    pop_rx("t1_pop1", 8'h3C);
    check("t1_empty", 8'(bus.rx_avail), 8'h00);
    clear_flags();
    check("t1_unf_cleared", 8'(bus.tx_underflow), 8'h00);

    // Overflow: five bytes into a four-deep FIFO.
    cs_on();
    for (int b = 1; b <= 5; b++) spi_xfer(8'(b), 8, 0, 8'h00, mi);
    cs_off();
    check("t2_avail", 8'(bus.rx_avail), 8'h01);
    check("t2_ovf", 8'(bus.rx_overflow), 8'h01);
    pop_rx("t2_pop0", 8'h01);
    pop_rx("t2_pop1", 8'h02);
    pop_rx("t2_pop2", 8'h03);
    pop_rx("t2_pop3", 8'h04);
    check("t2_empty", 8'(bus.rx_avail), 8'h00);
    clear_flags();

    // Abort after five bits, then a clean byte.
    cs_on();
    spi_xfer(8'hFF, 5, 0, 8'h00, mi);
    check("t3_oe_mid", 8'(bus.spi_miso_oe), 8'h01);
    x0 = xfer_cnt;
    cs_off();
    check("t3_xfer_pulses", 8'(xfer_cnt - x0), 8'h01);
    check("t3_oe_off", 8'(bus.spi_miso_oe), 8'h00);
    check("t3_miso_off", 8'(bus.spi_miso), 8'h00);
    check("t3_fifo_unchanged", 8'(bus.rx_avail), 8'h00);
    cs_on();
    spi_xfer(8'hC3, 8, 0, 8'h00, mi);
    cs_off();
    pop_rx("t3_pop", 8'hC3);
    check("t3_empty", 8'(bus.rx_avail), 8'h00);
    clear_flags();

    // tx_put coinciding with the byte-boundary transfer of 8'h11.
    put_tx(8'h33);
    cs_on();
    check("t4_free_after_load", 8'(bus.tx_free), 8'h01);
    put_tx(8'h11);
    check("t4_free_holding11", 8'(bus.tx_free), 8'h00);
    spi_xfer(8'hAA, 8, 1, 8'h22, mi);
    check("t4_miso0", mi, 8'h33);
    check("t4_free_holding22", 8'(bus.tx_free), 8'h00);
    spi_xfer(8'hBB, 8, 0, 8'h00, mi);
    check("t4_miso1", mi, 8'h11);
    check("t4_free_before_take", 8'(bus.tx_free), 8'h00);
    tick(5);
    check("t4_free_after_take", 8'(bus.tx_free), 8'h01);
    check("t4_unf", 8'(bus.tx_underflow), 8'h00);
    spi_xfer(8'hCC, 8, 0, 8'h00, mi);
    check("t4_miso2", mi, 8'h22);
    cs_off();
    pop_rx("t4_pop0", 8'hAA);
    pop_rx("t4_pop1", 8'hBB);
    pop_rx("t4_pop2", 8'hCC);
    check("t4_empty", 8'(bus.rx_avail), 8'h00);
    clear_flags();

    // Pop and push together on a full FIFO.
    cs_on();
    spi_xfer(8'h10, 8, 0, 8'h00, mi);
    spi_xfer(8'h20, 8, 0, 8'h00, mi);
    spi_xfer(8'h30, 8, 0, 8'h00, mi);
    spi_xfer(8'h40, 8, 0, 8'h00, mi);
    spi_xfer(8'h50, 8, 2, 8'h00, mi);
    cs_off();
    check("t5_ovf", 8'(bus.rx_overflow), 8'h00);
    pop_rx("t5_pop0", 8'h20);
    pop_rx("t5_pop1", 8'h30);
    pop_rx("t5_pop2", 8'h40);
    pop_rx("t5_pop3", 8'h50);
    check("t5_empty", 8'(bus.rx_avail), 8'h00);
    clear_flags();

    // First-byte content with a full FIFO, overflow and flag_clear.
    cs_on();
    for (int b = 0; b < 4; b++) spi_xfer(8'(8'h61 + b), 8, 0, 8'h00, mi);
    cs_off();
    clear_flags();
    check("t6_ovf_clr", 8'(bus.rx_overflow), 8'h00);
    check("t6_unf_clr", 8'(bus.tx_underflow), 8'h00);
    put_tx(8'h77);
    cs_on();
    spi_xfer(8'h55, 8, 0, 8'h00, mi);
`ifdef SPI_TGT_STATUS_BYTE_EN
    check("t6_first_b", mi, 8'h04);
`else
    check("t6_first_b", mi, 8'h77);
`endif
    cs_off();
    check("t6_ovf_set", 8'(bus.rx_overflow), 8'h01);
    check("t6_tx_free", 8'(bus.tx_free), 8'h01);
`ifdef SPI_TGT_STATUS_BYTE_EN
    check("t6_unf_b", 8'(bus.tx_underflow), 8'h00);
`else
    check("t6_unf_b", 8'(bus.tx_underflow), 8'h01);
`endif
    cs_on();
    spi_xfer(8'h56, 8, 0, 8'h00, mi);
`ifdef SPI_TGT_STATUS_BYTE_EN
    check("t6_first_c", mi, 8'hA4);
`else
    check("t6_first_c", mi, 8'hFF);
`endif
    cs_off();
    clear_flags();
    cs_on();
    spi_xfer(8'h57, 8, 0, 8'h00, mi);
`ifdef SPI_TGT_STATUS_BYTE_EN
    check("t6_first_d", mi, 8'h24);
`else
    check("t6_first_d", mi, 8'hFF);
`endif
    cs_off();
    pop_rx("t6_pop0", 8'h61);
    pop_rx("t6_pop1", 8'h62);
    pop_rx("t6_pop2", 8'h63);
    pop_rx("t6_pop3", 8'h64);
    check("t6_empty", 8'(bus.rx_avail), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_target_bridge.md
Name: spi_target_bridge

Overview:
SPI target (slave) for the SPI bus that the USB bridge endpoint drives as controller. Lets an external SPI controller exchange byte streams with fabric logic in the 48 MHz domain. Oversamples SCK/CS/MOSI and receives into a small RX FIFO. Returns bytes from a one-entry TX holding register. Handshakes mirror the endpoint data_avail/get and data_free/put style.

Parameters:
RX_DEPTH, 8, RX FIFO depth in bytes; power of two, 2..64.
FILL_BYTE, 8'hFF, byte shifted out when the TX holding register is empty at a byte boundary.

Ports:
clk  input  1  48 MHz system clock
reset  input  1  synchronous, active-high reset
spi_cs_b  input  1  chip select, active low (async to clk)
spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_mosi  input  1  controller-to-target data, MSB first
spi_miso  output  1  target-to-controller data
spi_miso_oe  output  1  MISO output enable; high only while CS is active (synced)
rx_data  output  8  head of RX FIFO
rx_avail  output  1  RX FIFO non-empty
rx_get  input  1  pop RX FIFO head; ignored when rx_avail=0
tx_data  input  8  byte to return
tx_put  input  1  load tx_data into holding register; ignored when tx_free=0
tx_free  output  1  TX holding register empty
cs_active  output  1  synced CS asserted
xfer_done  output  1  one-cycle pulse on synced CS deassertion
rx_overflow  output  1  sticky: RX byte dropped because FIFO full
tx_underflow  output  1  sticky: FILL_BYTE sent because holding register empty
flag_clear  input  1  clears both sticky flags

Behaviour:
- Reset is synchronous and active-high.
- Reset values: spi_miso=0, spi_miso_oe=0, rx_avail=0, rx_data=0, tx_free=1, cs_active=0, xfer_done=0, rx_overflow=0, tx_underflow=0. FIFO is emptied and bit counter is 0.
- Synchronisation: two-flop synchroniser on each SPI input, plus a third stage for edge detection.
  - Edge-to-action latency is 3 clk.
  - Supported SCK is at most clk/8 (6 MHz), with a minimum of 4 clk high and 4 clk low.
- States: IDLE -> (CS fall) LOAD -> SHIFT -> (CS rise) IDLE.
- LOAD lasts one cycle:
  - Loads the shift-out register from the holding register, or FILL_BYTE with tx_underflow set if it is empty.
  - Drives MSB on spi_miso, sets bit_cnt=0, asserts spi_miso_oe.
- SHIFT, SCK rising: shift spi_mosi into the RX shift register and increment bit_cnt (3-bit, wraps 7->0).
  - On the 8th bit, push the byte into the FIFO.
  - rx_avail rises on the next cycle.
  - If the FIFO is full, drop the byte and set rx_overflow.
- SHIFT, SCK falling:
  - If bit_cnt=0 (byte boundary): load the next TX byte, same rule as LOAD.
  - Otherwise shift the TX register left and drive the new MSB.
- Holding register transfer: tx_free rises the cycle after a transfer to the shift register.
- Simultaneous tx_put and transfer in the same cycle: the transfer takes the old contents and the new byte is held, so tx_free stays 0.
- Simultaneous push and rx_get with the FIFO full: pop first, then push. The byte is accepted and there is no overflow.
- CS rise mid-byte (abort):
  - Discard the partial RX byte and any partially shifted TX byte; do not restore it.
  - bit_cnt=0, spi_miso_oe=0, spi_miso=0, xfer_done pulses, return to IDLE.
  - FIFO contents and holding register are kept.
- CS rise and SCK edge detected in the same cycle: CS wins and the edge is ignored.
- Sticky flags are set by events and cleared only by reset or flag_clear. If flag_clear and a set event occur in the same cycle, set wins.
- FIFO pointers are log2(RX_DEPTH)+1 bits wide; full = MSBs differ and LSBs equal.

Optional Feature:
SPI_TGT_STATUS_BYTE_EN
- Defined: the byte loaded in LOAD is always a status byte {rx_overflow, tx_underflow, tx_free, rx_level[4:0]}.
  - rx_level is the FIFO occupancy, saturated at 31.
  - It does not consume the holding register and does not set tx_underflow.
  - Later byte boundaries follow the normal rule.
- Undefined: LOAD uses the normal holding-register/FILL_BYTE rule. Status bits remain readable only on ports.

Test Plan:
- Preload tx_put 8'h5A; controller sends 8'hA5 then 8'h3C with CS held low -> MISO sees 8'h5A then FILL 8'hFF; rx pops 8'hA5, 8'h3C; tx_underflow=1; xfer_done one pulse.
- RX_DEPTH=4, no rx_get, send 5 bytes 01..05 -> rx_avail=1, rx_overflow=1; pops 01,02,03,04; byte 05 lost.
- Send 5 bits then release CS -> FIFO unchanged, xfer_done=1, spi_miso_oe=0; next full byte 8'hC3 received intact.
- tx_put issued in the same cycle as byte-boundary transfer of 8'h11, new byte 8'h22 -> MISO sends 11 then 22; tx_free=0 until the 22 transfer.
- FIFO full, rx_get asserted in the same cycle as a push -> no overflow; level stays 4.
- With SPI_TGT_STATUS_BYTE_EN, after overflow, FIFO holding 4 bytes, holding register empty -> first MISO byte 8'b1010_0100; flag_clear then sets it to 8'b0010_0100.
